// File: rtl/legv8_alu_arbiter_if.sv
// Bundle of requester, ALU-side and response signals for the LEGv8 ALU arbiter.
// The slave modport is the arbiter; the master is the surrounding environment.
interface legv8_alu_arbiter_if #(
  parameter int unsigned DATA_W = 64
);
  logic              r0_valid;
  logic              r0_ready;
  logic [1:0]        r0_aluop;
  logic [10:0]       r0_opcode;
  logic [DATA_W-1:0] r0_a;
  logic [DATA_W-1:0] r0_b;

  logic              r1_valid;
  logic              r1_ready;
  logic [1:0]        r1_aluop;
  logic [10:0]       r1_opcode;
  logic [DATA_W-1:0] r1_a;
  logic [DATA_W-1:0] r1_b;

  logic [1:0]        alu_aluop;
  logic [10:0]       alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              busy;

  modport master (
    output r0_valid, r0_aluop, r0_opcode, r0_a, r0_b,
    output r1_valid, r1_aluop, r1_opcode, r1_a, r1_b,
    output alu_result, alu_zero, rsp_ready,
    input  r0_ready, r1_ready,
    input  alu_aluop, alu_opcode, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );

  modport slave (
    input  r0_valid, r0_aluop, r0_opcode, r0_a, r0_b,
    input  r1_valid, r1_aluop, r1_opcode, r1_a, r1_b,
    input  alu_result, alu_zero, rsp_ready,
    output r0_ready, r1_ready,
    output alu_aluop, alu_opcode, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/legv8_alu_arbiter.sv
// Round-robin arbiter sharing one combinational LEGv8 ALU between two requesters.
// One operation in flight: accept (IDLE) -> ALU evaluates (EXEC) -> hold response (RESP).
module legv8_alu_arbiter #(
  parameter int unsigned DATA_W = 64
) (
  input  logic               clk,
  input  logic               reset,
  legv8_alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic              last_served_q, last_served_d;
  logic              grant_id_q, grant_id_d;
  logic [1:0]        alu_aluop_q, alu_aluop_d;
  logic [10:0]       alu_opcode_q, alu_opcode_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic is_idle;
  logic pick_r1;
  logic accept;

  assign is_idle = (state_q == StIdle);

  // Under contention the requester not served last wins; otherwise whoever is valid.
  assign pick_r1 = (bus.r0_valid && bus.r1_valid) ? ~last_served_q : bus.r1_valid;
  assign accept  = is_idle && (bus.r0_valid || bus.r1_valid);

  assign bus.r0_ready = is_idle && bus.r0_valid && !pick_r1;
  assign bus.r1_ready = is_idle && bus.r1_valid && pick_r1;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    grant_id_d    = grant_id_q;
    alu_aluop_d   = alu_aluop_q;
    alu_opcode_d  = alu_opcode_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          grant_id_d = pick_r1;
          // Only the winner's payload is sampled.
          if (pick_r1) begin
            alu_aluop_d  = bus.r1_aluop;
            alu_opcode_d = bus.r1_opcode;
            alu_a_d      = bus.r1_a;
            alu_b_d      = bus.r1_b;
          end else begin
            alu_aluop_d  = bus.r0_aluop;
            alu_opcode_d = bus.r0_opcode;
            alu_a_d      = bus.r0_a;
            alu_b_d      = bus.r0_b;
          end
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_data_d    = bus.alu_result;
        rsp_zero_d    = bus.alu_zero;
        rsp_id_d      = grant_id_q;
        last_served_d = grant_id_q;
        state_d       = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      grant_id_q    <= 1'b0;
      alu_aluop_q   <= '0;
      alu_opcode_q  <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_id_q      <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      grant_id_q    <= grant_id_d;
      alu_aluop_q   <= alu_aluop_d;
      alu_opcode_q  <= alu_opcode_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
    end
  end

  assign bus.alu_aluop  = alu_aluop_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.busy       = !is_idle;

endmodule

// File: tb/tb_legv8_alu_arbiter.sv
// Directed bench for legv8_alu_arbiter with a small LEGv8 ALU model closing the loop.
module tb_legv8_alu_arbiter;

  localparam logic [10:0] OpAdd = 11'b10001011000;
  localparam logic [10:0] OpSub = 11'b11001011000;
  localparam logic [10:0] OpAnd = 11'b10001010000;
  localparam logic [10:0] OpOrr = 11'b10101010000;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  legv8_alu_arbiter_if #(.DATA_W(64)) bus ();

  legv8_alu_arbiter #(
    .DATA_W (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] alu_r;
  always_comb begin
    alu_r = '0;
    case (bus.alu_aluop)
      2'b00: alu_r = bus.alu_a + bus.alu_b;
      2'b01: alu_r = bus.alu_b;
      default: begin
        case (bus.alu_opcode)
          OpAdd:   alu_r = bus.alu_a + bus.alu_b;
          OpSub:   alu_r = bus.alu_a - bus.alu_b;
          OpAnd:   alu_r = bus.alu_a & bus.alu_b;
          OpOrr:   alu_r = bus.alu_a | bus.alu_b;
          default: alu_r = '0;
        endcase
      end
    endcase
    bus.alu_result = alu_r;
    bus.alu_zero   = (alu_r == 64'd0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_r0(input logic [1:0] op, input logic [10:0] opc,
                        input logic [63:0] a, input logic [63:0] b);
    bus.r0_valid  = 1'b1;
    bus.r0_aluop  = op;
    bus.r0_opcode = opc;
    bus.r0_a      = a;
    bus.r0_b      = b;
  endtask

  task automatic set_r1(input logic [1:0] op, input logic [10:0] opc,
                        input logic [63:0] a, input logic [63:0] b);
    bus.r1_valid  = 1'b1;
    bus.r1_aluop  = op;
    bus.r1_opcode = opc;
    bus.r1_a      = a;
    bus.r1_b      = b;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_busy"}, {63'd0, bus.busy}, 64'd0);
    check({pfx, "_rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
    check({pfx, "_rsp_id"}, {63'd0, bus.rsp_id}, 64'd0);
    check({pfx, "_rsp_data"}, bus.rsp_data, 64'd0);
    check({pfx, "_rsp_zero"}, {63'd0, bus.rsp_zero}, 64'd0);
    check({pfx, "_alu_aluop"}, {62'd0, bus.alu_aluop}, 64'd0);
    check({pfx, "_alu_opcode"}, {53'd0, bus.alu_opcode}, 64'd0);
    check({pfx, "_alu_a"}, bus.alu_a, 64'd0);
    check({pfx, "_alu_b"}, bus.alu_b, 64'd0);
  endtask

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int prev;
    logic gid;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.r0_valid = 1'b0; bus.r0_aluop = '0; bus.r0_opcode = '0; bus.r0_a = '0; bus.r0_b = '0;
    bus.r1_valid = 1'b0; bus.r1_aluop = '0; bus.r1_opcode = '0; bus.r1_a = '0; bus.r1_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) step();
    check_reset_vals("rst");
    reset = 1'b0;

    // Single add from r0: 5 + 7 = 12.
    set_r0(2'b00, 11'd0, 64'd5, 64'd7);
    #1;
    check("add_r0_ready", {63'd0, bus.r0_ready}, 64'd1);
    check("add_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    step();
    bus.r0_valid = 1'b0;
    #1;
    check("add_exec_busy", {63'd0, bus.busy}, 64'd1);
    check("add_exec_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("add_alu_a", bus.alu_a, 64'd5);
    check("add_alu_b", bus.alu_b, 64'd7);
    step();
    check("add_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("add_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
    check("add_rsp_data", bus.rsp_data, 64'd12);
    check("add_rsp_zero", {63'd0, bus.rsp_zero}, 64'd0);
    bus.rsp_ready = 1'b1;
    step();
    check("add_done_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("add_done_busy", {63'd0, bus.busy}, 64'd0);
    bus.rsp_ready = 1'b0;

    // Zero flag from r1: SUB 0x1234 - 0x1234.
    set_r1(2'b10, OpSub, 64'h1234, 64'h1234);
    #1;
    check("sub_r1_ready", {63'd0, bus.r1_ready}, 64'd1);
    check("sub_r0_ready", {63'd0, bus.r0_ready}, 64'd0);
    step();
    bus.r1_valid = 1'b0;
    step();
    check("sub_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("sub_rsp_id", {63'd0, bus.rsp_id}, 64'd1);
    check("sub_rsp_data", bus.rsp_data, 64'd0);
    check("sub_rsp_zero", {63'd0, bus.rsp_zero}, 64'd1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Contention: r0 AND 0xF0&0x3C=0x30 first, then r1 ORR 0xF0|0x0F=0xFF.
    set_r0(2'b10, OpAnd, 64'hF0, 64'h3C);
    set_r1(2'b10, OpOrr, 64'hF0, 64'h0F);
    #1;
    check("cont_r0_ready", {63'd0, bus.r0_ready}, 64'd1);
    check("cont_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    step();
    bus.r0_valid = 1'b0;
    #1;
    check("cont_exec_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    check("cont_alu_b", bus.alu_b, 64'h3C);
    step();
    check("cont_rsp0_id", {63'd0, bus.rsp_id}, 64'd0);
    check("cont_rsp0_data", bus.rsp_data, 64'h30);
    check("cont_resp_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    bus.rsp_ready = 1'b1;
    step();
    #1;
    check("cont_idle_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("cont_idle_r1_ready", {63'd0, bus.r1_ready}, 64'd1);
    check("cont_alu_opcode_held", {53'd0, bus.alu_opcode}, {53'd0, OpAnd});
    step();
    bus.r1_valid = 1'b0;
    step();
    check("cont_rsp1_valid", {63'd0, bus.rsp_valid}, 64'd1);
    check("cont_rsp1_id", {63'd0, bus.rsp_id}, 64'd1);
    check("cont_rsp1_data", bus.rsp_data, 64'hFF);
    step();

    // Fairness: both valid, r0 computes 1+1=2, r1 computes 2+2=4.
    set_r0(2'b00, 11'd0, 64'd1, 64'd1);
    set_r1(2'b00, 11'd0, 64'd2, 64'd2);
    n    = 0;
    prev = 0;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      #1;
      if (bus.r0_ready && bus.r1_ready) begin
        check("fair_both_ready", 64'd1, 64'd0);
      end
      if (bus.r0_ready || bus.r1_ready) begin
        gid = bus.r1_ready;
        check("fair_id", {63'd0, gid}, (n % 2 == 1) ? 64'd1 : 64'd0);
        if (n > 0) check("fair_gap", 64'(cyc - prev), 64'd3);
        prev = cyc;
        n++;
      end
      if (bus.rsp_valid) begin
        check("fair_rsp_data", bus.rsp_data, bus.rsp_id ? 64'd4 : 64'd2);
      end
      step();
    end
    check("fair_count", 64'(n), 64'd6);
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    step();
    step();

    // Backpressure: r0 3+4=7 held 5 cycles while r1 (100+1=101) waits.
    bus.rsp_ready = 1'b0;
    set_r0(2'b00, 11'd0, 64'd3, 64'd4);
    #1;
    check("bp_r0_ready", {63'd0, bus.r0_ready}, 64'd1);
    step();
    bus.r0_valid = 1'b0;
    set_r1(2'b00, 11'd0, 64'd100, 64'd1);
    #1;
    check("bp_exec_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
      check("bp_rsp_data", bus.rsp_data, 64'd7);
      check("bp_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
      check("bp_rsp_zero", {63'd0, bus.rsp_zero}, 64'd0);
      check("bp_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
      check("bp_busy", {63'd0, bus.busy}, 64'd1);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_hs_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    step();
    #1;
    check("bp_idle_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("bp_idle_r1_ready", {63'd0, bus.r1_ready}, 64'd1);
    step();
    bus.r1_valid = 1'b0;
    step();
    check("bp_rsp1_id", {63'd0, bus.rsp_id}, 64'd1);
    check("bp_rsp1_data", bus.rsp_data, 64'd101);
    step();

    // Reset mid-op: r0 served last (9), then a second r0 op is dropped in EXEC.
    set_r0(2'b01, 11'd0, 64'd0, 64'd9);
    step();
    bus.r0_valid = 1'b0;
    step();
    check("rmid_pre_data", bus.rsp_data, 64'd9);
    step();
    set_r0(2'b00, 11'd0, 64'd6, 64'd6);
    #1;
    check("rmid_r0_ready", {63'd0, bus.r0_ready}, 64'd1);
    step();
    bus.r0_valid = 1'b0;
    reset = 1'b1;
    step();
    check_reset_vals("rmid");
    reset = 1'b0;
    set_r0(2'b00, 11'd0, 64'd1, 64'd2);
    set_r1(2'b00, 11'd0, 64'd3, 64'd4);
    #1;
    check("rmid_cont_r0_ready", {63'd0, bus.r0_ready}, 64'd1);
    check("rmid_cont_r1_ready", {63'd0, bus.r1_ready}, 64'd0);
    step();
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    step();
    check("rmid_post_data", bus.rsp_data, 64'd3);
    check("rmid_post_id", {63'd0, bus.rsp_id}, 64'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/legv8_alu_arbiter.md
# legv8_alu_arbiter

Two-port round-robin arbiter and sequencer that shares one 64-bit LEGv8 ALU-with-control unit between two requesters, for example the main execute path and an address/branch-compare helper. It accepts one operation at a time over a valid/ready handshake and drives registered operands into the shared ALU. It captures ALU_result/Zero one cycle later and returns them, tagged with the requester ID, over a valid/ready response channel. The ALU itself stays combinational and outside this block.

## Interface
- DATA_W, 64, operand/result width; must match the ALU.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- r0_valid / r1_valid  in  1  requester 0/1 has an operation.
- r0_ready / r1_ready  out  1  operation accepted this cycle.
- r0_aluop / r1_aluop  in  2  ALUOp field.
- r0_opcode / r1_opcode  in  11  Opcode_field.
- r0_a, r0_b / r1_a, r1_b  in  DATA_W  operands.
- alu_aluop  out  2  to ALU ALUOp.
- alu_opcode  out  11  to ALU Opcode_field.
- alu_a, alu_b  out  DATA_W  to ALU A/B.
- alu_result  in  DATA_W  from ALU ALU_result.
- alu_zero  in  1  from ALU Zero.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_data  out  DATA_W  captured ALU result.
- rsp_zero  out  1  captured Zero flag.
- busy  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE: if any rX_valid, select a winner, assert its rX_ready combinationally, latch aluop/opcode/a/b into the alu_* registers and the winner into grant_id; next state EXEC. No valid: stay in IDLE.
  - EXEC: the ALU sees stable registered inputs. Capture alu_result to rsp_data, alu_zero to rsp_zero, grant_id to rsp_id; set last_served = grant_id; next state RESP.
  - RESP: rsp_valid=1. On rsp_ready=1, clear rsp_valid and go to IDLE. Otherwise hold.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_served wins.
  - last_served resets to 1, so requester 0 wins the first contention.
- rX_ready is high only in IDLE, only for the winner, and only while its rX_valid is high. It is never high for both requesters in the same cycle.
- Requesters hold valid and payload stable until ready. The arbiter does not sample a losing requester's payload.
- alu_* outputs hold their last issued values outside IDLE-accept; they change only on acceptance.
- rsp_data/rsp_zero/rsp_id hold stable while rsp_valid=1 and rsp_ready=0.
- No new request is accepted in EXEC or RESP; one operation is in flight at most.
- The result is the ALU's DATA_W-bit output unchanged; the block applies no extension or truncation.

## Timing
- Reset values: state=IDLE, r0_ready=r1_ready=0 (given valid low), alu_aluop=0, alu_opcode=0, alu_a=alu_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0, busy=0, last_served=1.
- Reset asserted in any state: the in-flight operation is dropped with no response, and all of the above values load at the next edge.
- Latency:
  - Acceptance at edge N (rX_valid & rX_ready high in cycle N-1).
  - EXEC during cycle N, capture at edge N+1.
  - rsp_valid=1 from cycle N+1.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with rsp_ready=1 immediately, then IDLE.
- rsp_ready held low: RESP persists indefinitely, busy=1, and both rX_ready stay 0.
- rX_valid rising in EXEC/RESP: no effect until IDLE.
- Simultaneous rsp handshake and new request: the request is handled in the following IDLE cycle, never in RESP.

## Test plan
- Single add: r0 sends aluop=00, a=5, b=7 -> r0_ready pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
- Zero flag: r1 sends aluop=10, opcode=11001011000 (SUB), a=b=0x1234 -> rsp_id=1, rsp_data=0, rsp_zero=1.
- Contention after reset: r0 and r1 both valid with distinct ops -> r0 served first, then r1. Responses arrive in order with id 0 then id 1, and r1's payload stays held until its ready.
- Fairness: both valid continuously for 6 operations, rsp_ready=1 -> grants alternate 0,1,0,1,0,1, one issue every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with r1 valid -> rsp_data/id/zero stable, r1_ready=0 throughout. On rsp_ready=1, r1 is accepted in the next IDLE cycle.
- Reset mid-op: assert reset in EXEC -> next cycle all outputs at reset values, no rsp_valid; the next contention is won by r0.
